op_result_buffer: RTL and testbench

// - Downstream stage of the 8-bit operand datapath. Captures each 8-bit result, paired with
//   a valid strobe, into a small first-in first-out buffer (FIFO).
// - Drains the buffer to the output pins through a valid/ready handshake.
// - Keeps a saturating running sum of every accepted result, plus a sticky overflow flag.
// - Sits between the operator block's Y output and the uo_out/uio drivers in the
//   top-level wrapper.

---
 rtl/op_pkg.sv | 16 +
 rtl/sync_fifo_core.sv | 80 ++++++++
 rtl/op_result_buffer.sv | 92 +++++++++
 tb/tb_op_result_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
// Shared constants and types for the 8-bit operand datapath result stage.
// The occupancy enum is the buffer's externally visible state.
package op_pkg;

    localparam int OP_DATA_W     = 8;
    localparam int OP_FIFO_DEPTH = 4;
    localparam int OP_ACC_W      = 12;
    localparam int OP_LVL_W      = $clog2(OP_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/sync_fifo_core.sv
// Storage, read/write pointers and occupancy counter of a small synchronous FIFO.
// Callers guarantee push only when !full and pop only when !empty.
module sync_fifo_core
    import op_pkg::*;
#(
    parameter  int DATA_W = OP_DATA_W,
    parameter  int DEPTH  = OP_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output occ_e              occ
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Entries carry no reset; they are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // Forcing zero while empty gives a clean out_data after reset without resetting storage.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        occ = OCC_PART;
        if (empty) begin
            occ = OCC_EMPTY;
        end else if (full) begin
            occ = OCC_FULL;
        end
    end

endmodule

// File: rtl/op_result_buffer.sv
// Result buffer: FIFO between the operator stage and the output pins, plus a
// saturating running sum of accepted words and a sticky push-while-full flag.
module op_result_buffer
    import op_pkg::*;
#(
    parameter  int DATA_W = OP_DATA_W,
    parameter  int DEPTH  = OP_FIFO_DEPTH,
    parameter  int ACC_W  = OP_ACC_W,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic [LVL_W-1:0]  level,
    output occ_e              occ_dbg
);

    // Handshake: a word moves only when valid and ready are both high at the
    // rising edge; in_ready and out_valid are functions of registered level only.
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ovf_attempt;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    sync_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (out_data),
        .level (level),
        .full  (full),
        .empty (empty),
        .occ   (occ_dbg)
    );

    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign ovf_attempt = in_valid & full;

    // One extra bit of sum width; its carry selects the saturated value.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (acc_clr && push) begin
            acc_d = {{(ACC_W - DATA_W){1'b0}}, in_data};
        end else if (acc_clr) begin
            acc_d = '0;
        end else if (push) begin
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
        if (acc_clr) begin
            ovf_d = 1'b0;
        end else if (ovf_attempt) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_op_result_buffer.sv
// Bench for op_result_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer and accumulator.
module tb_op_result_buffer;
    import op_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ACC_MAX = 4095;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       acc_clr = 1'b0;
    logic [11:0] acc_out;
    logic       ovf;
    logic [2:0] level;
    occ_e       occ_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: stored words, running sum, sticky flag.
    logic [7:0] exp_q[$];
    int         acc_m = 0;
    logic       ovf_m = 1'b0;

    op_result_buffer dut (
        .clk       (clk),
        .reset     (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_clr   (acc_clr),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .level     (level),
        .occ_dbg   (occ_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: inputs set 1 time unit after a rising edge, captured at the next one.
    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        acc_clr   = c;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic occ_e occ_of(input int n);
        if (n == 0) return OCC_EMPTY;
        if (n == DEPTH) return OCC_FULL;
        return OCC_PART;
    endfunction

    // Scoreboard: compare on the falling edge, then advance the model with the
    // inputs that the next rising edge will capture.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_m = 0;
                ovf_m = 1'b0;
            end
            check("level", 32'(level), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
            check("occ_dbg", 32'(occ_dbg), 32'(occ_of(exp_q.size())));
            check("acc_out", 32'(acc_out), 32'(acc_m));
            check("ovf", 32'(ovf), 32'(ovf_m));
            if (exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
            if (!rst) begin
                bit full_m, push_m, pop_m;
                full_m = (exp_q.size() == DEPTH);
                push_m = in_valid && !full_m;
                pop_m  = out_ready && (exp_q.size() > 0);
                if (acc_clr) begin
                    acc_m = push_m ? int'(in_data) : 0;
                    ovf_m = 1'b0;
                end else begin
                    if (push_m) acc_m = (acc_m + in_data > ACC_MAX) ? ACC_MAX : acc_m + in_data;
                    if (in_valid && full_m) ovf_m = 1'b1;
                end
                if (pop_m) void'(exp_q.pop_front());
                if (push_m) exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-stream
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd2);
        rst = 1'b1;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("rst_first_pop", 32'(out_data), 32'h33);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Order and latency
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        check("lat_before", 32'(out_valid), 32'd0);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        check("lat_after", 32'(out_valid), 32'd1);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("order_level", 32'(level), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check("order_word", 32'(out_data), 32'(i));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("order_empty", 32'(out_valid), 32'd0);

        // Full and overflow, then clear winning over an overflow attempt
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i * 10), 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        drive(1'b1, 8'h60, 1'b0, 1'b1);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_acc", 32'(acc_out), 32'd100);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("clr_beats_ovf", 32'(ovf), 32'd0);
        check("clr_acc_zero", 32'(acc_out), 32'd0);
        check("clr_keeps_level", 32'(level), 32'd4);
        drain();

        // Simultaneous push and pop at level 2
        drive(1'b1, 8'h07, 1'b0, 1'b0);
        drive(1'b1, 8'h08, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            check("pp_level", 32'(level), 32'd2);
        end
        drain();

        // Saturation, then clear together with a push
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) drive(1'b1, 8'hFF, 1'b1, 1'b0);
        drive(1'b1, 8'h05, 1'b1, 1'b1);
        check("sat_acc", 32'(acc_out), 32'hFFF);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("clr_push_acc", 32'(acc_out), 32'h005);
        check("clr_push_ovf", 32'(ovf), 32'd0);
        drain();

        // Push and pop request while empty
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        check("empty_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("empty_data", 32'(out_data), 32'hAA);
        check("empty_level", 32'(level), 32'd1);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end
        drain();

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
